seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a 4-digit common-anode 7-segment display.
- Produces the hex nibble, LE (blank) and decimal-point inputs that the team's segment decoder consumes, plus active-low digit anode selects.
- Sits between the user datapath (switch and counter logic) and the segment decoder.
- Uses a load handshake with a shadow register, so the displayed frame never tears.

---
 rtl/seg7_scan_driver.sv | 106 ++++++++++
 tb/tb_seg7_scan_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with a tear-free shadow/active frame buffer.
// All outputs decode registered state; a new frame is committed only at the end of digit 3.
module seg7_scan_driver #(
  parameter int SCAN_PERIOD = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] hex,
  input  logic [3:0]  points,
  input  logic [3:0]  blank,
  output logic [3:0]  digit_val,
  output logic        le,
  output logic        point,
  output logic [3:0]  anode,
  output logic [1:0]  digit_idx,
  output logic        pending,
  output logic        frame_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      act_hex_q, act_hex_d;
  logic [3:0]       act_points_q, act_points_d;
  logic [3:0]       act_blank_q, act_blank_d;
  logic [15:0]      sh_hex_q, sh_hex_d;
  logic [3:0]       sh_points_q, sh_points_d;
  logic [3:0]       sh_blank_q, sh_blank_d;
  logic             pending_q, pending_d;

  logic last_cnt;
  logic frame_end;

  always_comb begin
    last_cnt  = (cnt_q == CNT_W'(SCAN_PERIOD - 1));
    frame_end = last_cnt && (idx_q == 2'd3);

    cnt_d        = last_cnt ? '0 : cnt_q + CNT_W'(1);
    idx_d        = last_cnt ? idx_q + 2'd1 : idx_q;
    act_hex_d    = act_hex_q;
    act_points_d = act_points_q;
    act_blank_d  = act_blank_q;
    sh_hex_d     = sh_hex_q;
    sh_points_d  = sh_points_q;
    sh_blank_d   = sh_blank_q;
    pending_d    = pending_q;

    if (load) begin
      sh_hex_d    = hex;
      sh_points_d = points;
      sh_blank_d  = blank;
      pending_d   = 1'b1;
    end

    // A load landing on the frame boundary bypasses the shadow so it is not delayed a whole frame.
    if (frame_end) begin
      if (load) begin
        act_hex_d    = hex;
        act_points_d = points;
        act_blank_d  = blank;
      end else if (pending_q) begin
        act_hex_d    = sh_hex_q;
        act_points_d = sh_points_q;
        act_blank_d  = sh_blank_q;
      end
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      act_hex_q    <= 16'h0000;
      act_points_q <= 4'b0000;
      act_blank_q  <= 4'b1111;
      sh_hex_q     <= 16'h0000;
      sh_points_q  <= 4'b0000;
      sh_blank_q   <= 4'b0000;
      pending_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_hex_q    <= act_hex_d;
      act_points_q <= act_points_d;
      act_blank_q  <= act_blank_d;
      sh_hex_q     <= sh_hex_d;
      sh_points_q  <= sh_points_d;
      sh_blank_q   <= sh_blank_d;
      pending_q    <= pending_d;
    end
  end

  // The first cycle of each digit keeps all anodes off to hide the segment change.
  always_comb begin
    anode      = (cnt_q == '0) ? 4'b1111 : ~(4'b0001 << idx_q);
    digit_val  = act_hex_q[{idx_q, 2'b00} +: 4];
    le         = act_blank_q[idx_q];
    point      = act_points_q[idx_q] & ~act_blank_q[idx_q];
    digit_idx  = idx_q;
    pending    = pending_q;
    frame_tick = frame_end;
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at SCAN_PERIOD=4: a cycle-indexed frame model predicts every output.
module tb_seg7_scan_driver;

  localparam int SP    = 4;
  localparam int FRAME = 4 * SP;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] hex;
  logic [3:0]  points;
  logic [3:0]  blank;
  logic [3:0]  digit_val;
  logic        le;
  logic        point;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        pending;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_PERIOD(SP), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .load(load), .hex(hex), .points(points), .blank(blank),
    .digit_val(digit_val), .le(le), .point(point), .anode(anode),
    .digit_idx(digit_idx), .pending(pending), .frame_tick(frame_tick)
  );

  // Reference model: time since reset plus the displayed and waiting frames
  int          m_t;
  logic [15:0] m_act_hex, m_sh_hex;
  logic [3:0]  m_act_pts, m_act_blk, m_sh_pts, m_sh_blk;
  logic        m_pend;

  // Expected output vector {anode, digit_val, le, point, digit_idx, pending, frame_tick}
  logic [13:0] exp_q[$];

  function automatic logic [13:0] model_out();
    int cnt = m_t % SP;
    int idx = (m_t / SP) % 4;
    logic [3:0]  an;
    logic [15:0] sh;
    for (int k = 0; k < 4; k++) an[k] = !((k == idx) && (cnt != 0));
    sh = m_act_hex >> (4 * idx);
    return {an, sh[3:0], m_act_blk[idx], m_act_pts[idx] & ~m_act_blk[idx],
            2'(idx), m_pend, 1'((m_t % FRAME) == FRAME - 1)};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {anode, digit_val, le, point, digit_idx, pending, frame_tick};
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_act_hex = 16'h0; m_act_pts = 4'h0; m_act_blk = 4'hF;
    m_sh_hex = 16'h0; m_sh_pts = 4'h0; m_sh_blk = 4'h0;
    m_pend = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] h, input logic [3:0] p,
                            input logic [3:0] b);
    bit boundary = ((m_t % FRAME) == FRAME - 1);
    bit old_pend = m_pend;
    if (ld) begin
      m_sh_hex = h; m_sh_pts = p; m_sh_blk = b; m_pend = 1'b1;
    end
    if (boundary) begin
      if (ld) begin
        m_act_hex = h; m_act_pts = p; m_act_blk = b;
      end else if (old_pend) begin
        m_act_hex = m_sh_hex; m_act_pts = m_sh_pts; m_act_blk = m_sh_blk;
      end
      m_pend = 1'b0;
    end
    m_t++;
  endtask

  // Driver tasks: each call starts and ends on a falling edge
  task automatic drive_cycle(input logic ld, input logic [15:0] h, input logic [3:0] p,
                             input logic [3:0] b);
    load = ld; hex = h; points = p; blank = b;
    @(posedge clk);
    model_edge(ld, h, p, b);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (anode !== 4'b1111) begin n_fail++; $display("FAIL reset_anode got=%b exp=1111", anode); end
    n_tests++; if (le !== 1'b1) begin n_fail++; $display("FAIL reset_le got=%b exp=1", le); end
    n_tests++; if (point !== 1'b0) begin n_fail++; $display("FAIL reset_point got=%b exp=0", point); end
    n_tests++; if (digit_val !== 4'h0) begin n_fail++; $display("FAIL reset_digit_val got=%h exp=0", digit_val); end
    n_tests++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
    n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", pending); end
    n_tests++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
  endtask

  task automatic test_idle_scan();
    logic [3:0] an_tab[16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    logic [13:0] e;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      e = model_out();
      n_tests++;
      if (obs_vec() !== e) begin n_fail++; $display("FAIL idle_vec cyc=%0d got=%h exp=%h", c, obs_vec(), e); end
      n_tests++;
      if (anode !== an_tab[c] || le !== 1'b1 || frame_tick !== (c == 15)) begin
        n_fail++;
        $display("FAIL idle_scan cyc=%0d got an=%b le=%b ft=%b exp an=%b le=1 ft=%b",
                 c, anode, le, frame_tick, an_tab[c], (c == 15));
      end
      drive_cycle(1'b0, 16'h0, 4'h0, 4'h0);
    end
  endtask

  task automatic test_load_display();
    logic [3:0] nib[4] = '{4'hF, 4'h3, 4'hA, 4'h1};
    logic [13:0] e;
    int ticks = 0;
    int last_tick = -1;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      e = model_out();
      n_tests++;
      if (obs_vec() !== e) begin n_fail++; $display("FAIL load_vec cyc=%0d got=%h exp=%h", c, obs_vec(), e); end
      if (c >= 6) begin
        n_tests++;
        if (pending !== (c <= 15)) begin n_fail++; $display("FAIL load_pending cyc=%0d got=%b exp=%b", c, pending, (c <= 15)); end
      end
      if (c >= 16) begin
        n_tests++;
        if (digit_val !== nib[(c - 16) / 4] || le !== 1'b0 || point !== ((c - 16) / 4 == 2)) begin
          n_fail++;
          $display("FAIL load_show cyc=%0d got dv=%h le=%b pt=%b exp dv=%h le=0 pt=%b",
                   c, digit_val, le, point, nib[(c - 16) / 4], ((c - 16) / 4 == 2));
        end
      end
      drive_cycle(c == 5, 16'h1A3F, 4'b0100, 4'b0000);
    end
    // Long idle run: four ticks, one frame apart, display content untouched
    for (int c = 32; c < 96; c++) begin
      e = model_out();
      n_tests++;
      if (obs_vec() !== e) begin n_fail++; $display("FAIL idle64_vec cyc=%0d got=%h exp=%h", c, obs_vec(), e); end
      n_tests++;
      if (digit_val !== nib[(c % 16) / 4]) begin n_fail++; $display("FAIL idle64_dv cyc=%0d got=%h exp=%h", c, digit_val, nib[(c % 16) / 4]); end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          n_tests++;
          if (c - last_tick != 16) begin n_fail++; $display("FAIL tick_spacing cyc=%0d got=%0d exp=16", c, c - last_tick); end
        end
        ticks++;
        last_tick = c;
      end
      drive_cycle(1'b0, 16'h0, 4'h0, 4'h0);
    end
    n_tests++;
    if (ticks != 4) begin n_fail++; $display("FAIL tick_count got=%0d exp=4", ticks); end
  endtask

  task automatic test_last_write_wins();
    logic [13:0] e;
    int ones = 0;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      e = model_out();
      n_tests++;
      if (obs_vec() !== e) begin n_fail++; $display("FAIL lww_vec cyc=%0d got=%h exp=%h", c, obs_vec(), e); end
      if (digit_val === 4'h1 && le === 1'b0) ones++;
      if (c >= 16) begin
        n_tests++;
        if (digit_val !== 4'h2 || le !== 1'b0) begin n_fail++; $display("FAIL lww_show cyc=%0d got dv=%h le=%b exp dv=2 le=0", c, digit_val, le); end
      end
      if (c == 3)      drive_cycle(1'b1, 16'h1111, 4'h0, 4'h0);
      else if (c == 9) drive_cycle(1'b1, 16'h2222, 4'h0, 4'h0);
      else             drive_cycle(1'b0, 16'h0, 4'h0, 4'h0);
    end
    n_tests++;
    if (ones != 0) begin n_fail++; $display("FAIL lww_stale got=%0d exp=0 cycles showing 1", ones); end
  endtask

  task automatic test_boundary_bypass();
    logic [13:0] e;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      e = model_out();
      n_tests++;
      if (obs_vec() !== e) begin n_fail++; $display("FAIL bypass_vec cyc=%0d got=%h exp=%h", c, obs_vec(), e); end
      if (c == 16) begin
        n_tests++;
        if (digit_val !== 4'hF || pending !== 1'b0 || le !== 1'b0) begin
          n_fail++; $display("FAIL bypass_first got dv=%h pend=%b le=%b exp dv=f pend=0 le=0", digit_val, pending, le);
        end
      end
      if (c >= 28) begin
        n_tests++;
        if (le !== 1'b1 || point !== 1'b0) begin n_fail++; $display("FAIL bypass_blank3 cyc=%0d got le=%b pt=%b exp le=1 pt=0", c, le, point); end
      end
      drive_cycle(c == 15, 16'hBEEF, 4'b1000, 4'b1000);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [13:0] e;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      e = model_out();
      n_tests++;
      if (obs_vec() !== e) begin n_fail++; $display("FAIL midrst_vec cyc=%0d got=%h exp=%h", c, obs_vec(), e); end
      drive_cycle(c == 18, 16'h5555, 4'hF, 4'h0);
    end
    n_tests++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_pending got=%b exp=1", pending); end
    do_reset();
    n_tests++;
    if (anode !== 4'b1111 || le !== 1'b1 || pending !== 1'b0 || digit_idx !== 2'd0) begin
      n_fail++; $display("FAIL midrst_after got an=%b le=%b pend=%b idx=%0d exp an=1111 le=1 pend=0 idx=0",
                         anode, le, pending, digit_idx);
    end
    for (int c = 0; c < 32; c++) begin
      e = model_out();
      n_tests++;
      if (obs_vec() !== e) begin n_fail++; $display("FAIL midrst_post_vec cyc=%0d got=%h exp=%h", c, obs_vec(), e); end
      n_tests++;
      if (le !== 1'b1 || digit_val !== 4'h0) begin n_fail++; $display("FAIL midrst_dropped cyc=%0d got le=%b dv=%h exp le=1 dv=0", c, le, digit_val); end
      drive_cycle(1'b0, 16'h0, 4'h0, 4'h0);
    end
  endtask

  task automatic test_random();
    logic [13:0] e;
    logic        ld;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      exp_q.push_back(model_out());
      e = exp_q.pop_front();
      n_tests++;
      if (obs_vec() !== e) begin n_fail++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", c, obs_vec(), e); end
      ld = ($urandom_range(0, 5) == 0) || ((c % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1);
      drive_cycle(ld, 16'($urandom()), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; hex = 16'h0; points = 4'h0; blank = 4'h0;
    test_reset();
    test_idle_scan();
    test_load_display();
    test_last_write_wins();
    test_boundary_bypass();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
